// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
// Read-back states exist only when I2C_CFG_READBACK_EN is defined.
package i2c_cfg_pkg;

  localparam int   IDX_W   = 8;
  localparam int   WDATA_W = 24;
  localparam logic ACK_OK  = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_END,
    S_CHECK,
    S_GAP,
    S_DONE,
    S_FAIL
`ifdef I2C_CFG_READBACK_EN
    ,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_VERIFY
`endif
  } seq_state_e;

endpackage

// File: rtl/i2c_clk_gen.sv
// Free-running SCL-rate divider: I2C_CLK toggles every CLK_DIV cycles, and I2C_EN
// pulses for one cycle together with each 1->0 transition of I2C_CLK.
module i2c_clk_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic iCLK,
  input  logic iRST_N,
  output logic I2C_CLK,
  output logic I2C_EN
);

  localparam int                CNT_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  DIV_TC = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      div_cnt <= '0;
      I2C_CLK <= 1'b1;
      I2C_EN  <= 1'b0;
    end else begin
      I2C_EN <= 1'b0;
      if (div_cnt == DIV_TC) begin
        div_cnt <= '0;
        I2C_CLK <= ~I2C_CLK;
        I2C_EN  <= I2C_CLK;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks an external register table and issues one 3-byte I2C write per entry with
// NACK retry. Defining I2C_CFG_READBACK_EN adds a read-back verify after each write.
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int         CLK_DIV   = 250,
  parameter int         LUT_SIZE  = 32,
  parameter logic [7:0] DEV_ADDR  = 8'h42,
  parameter int         MAX_RETRY = 3,
  parameter int         GAP_TICKS = 4
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               START,
  output logic [IDX_W-1:0]   LUT_INDEX,
  input  logic [15:0]        LUT_DATA,
  output logic               I2C_CLK,
  output logic               I2C_EN,
  output logic [WDATA_W-1:0] I2C_WDATA,
  output logic               WR,
  output logic               GO,
  input  logic               ACK,
  input  logic               END,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERROR
`ifdef I2C_CFG_READBACK_EN
  ,
  input  logic [7:0]         I2C_RDATA
`endif
);

  // state      | meaning
  // IDLE       | waiting for START
  // LOAD       | latch {DEV_ADDR, LUT_DATA} for the current index
  // ISSUE      | raise GO
  // WAIT_END   | hold GO until END, capture ACK
  // CHECK      | judge write ACK: advance, retry or fail
  // GAP        | GO low for GAP_TICKS I2C_EN ticks
  // DONE/FAIL  | table finished / retries exhausted
  // RD_ISSUE   | raise GO with WR=0 (read-back build)
  // RD_WAIT    | hold GO until END, capture ACK and read data
  // VERIFY     | judge read-back: advance or retry the write

  localparam int                 RETRY_W   = 8;
  localparam int                 GAP_W     = 16;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(LUT_SIZE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(GAP_TICKS);

  seq_state_e           state_q, state_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [RETRY_W-1:0]   retry_q, retry_n;
  logic [GAP_W-1:0]     gap_q, gap_n;
  logic                 adv_q, adv_n;
  logic                 go_q, go_n;
  logic [WDATA_W-1:0]   wdata_q, wdata_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;
  logic                 err_q, err_n;
  logic                 ack_q, ack_n;
  logic                 xfer_ok;
`ifdef I2C_CFG_READBACK_EN
  logic                 wr_q, wr_n;
  logic                 rd_q, rd_n;
  logic                 match_q, match_n;

  assign xfer_ok = (ack_q == ACK_OK) && ((state_q != S_VERIFY) || match_q);
  assign WR      = wr_q;
`else
  assign xfer_ok = (ack_q == ACK_OK);
  assign WR      = 1'b1;
`endif

  i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .I2C_CLK (I2C_CLK),
    .I2C_EN  (I2C_EN)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      gap_q   <= '0;
      adv_q   <= 1'b0;
      go_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b1;
`ifdef I2C_CFG_READBACK_EN
      wr_q    <= 1'b1;
      rd_q    <= 1'b0;
      match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      retry_q <= retry_n;
      gap_q   <= gap_n;
      adv_q   <= adv_n;
      go_q    <= go_n;
      wdata_q <= wdata_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
      ack_q   <= ack_n;
`ifdef I2C_CFG_READBACK_EN
      wr_q    <= wr_n;
      rd_q    <= rd_n;
      match_q <= match_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    retry_n = retry_q;
    gap_n   = gap_q;
    adv_n   = adv_q;
    go_n    = go_q;
    wdata_n = wdata_q;
    busy_n  = busy_q;
    done_n  = done_q;
    err_n   = err_q;
    ack_n   = ack_q;
`ifdef I2C_CFG_READBACK_EN
    wr_n    = wr_q;
    rd_n    = rd_q;
    match_n = match_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (START) begin
          state_n = S_LOAD;
          idx_n   = '0;
          retry_n = '0;
          done_n  = 1'b0;
          err_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      S_LOAD: begin
        wdata_n = {DEV_ADDR, LUT_DATA};
`ifdef I2C_CFG_READBACK_EN
        wr_n    = 1'b1;
`endif
        state_n = S_ISSUE;
      end
      S_ISSUE: begin
        go_n    = 1'b1;
        state_n = S_WAIT_END;
      end
      S_WAIT_END: begin
        // GO falls on the same edge that samples END so the controller sees it next cycle
        if (END) begin
          ack_n   = ACK;
          go_n    = 1'b0;
          state_n = S_CHECK;
        end
      end
`ifdef I2C_CFG_READBACK_EN
      S_RD_ISSUE: begin
        go_n    = 1'b1;
        wr_n    = 1'b0;
        state_n = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (END) begin
          ack_n   = ACK;
          match_n = (I2C_RDATA == wdata_q[7:0]);
          go_n    = 1'b0;
          state_n = S_VERIFY;
        end
      end
      S_CHECK, S_VERIFY: begin
`else
      S_CHECK: begin
`endif
        go_n  = 1'b0;
        gap_n = GAP_LOAD;
        adv_n = 1'b0;
`ifdef I2C_CFG_READBACK_EN
        rd_n  = 1'b0;
`endif
        if (xfer_ok) begin
          state_n = S_GAP;
`ifdef I2C_CFG_READBACK_EN
          if (state_q == S_CHECK) rd_n = 1'b1;
          else                    adv_n = 1'b1;
`else
          adv_n = 1'b1;
`endif
        end else if (retry_q < RETRY_LIM) begin
          retry_n = retry_q + RETRY_W'(1);
          state_n = S_GAP;
        end else begin
          state_n = S_FAIL;
          busy_n  = 1'b0;
          err_n   = 1'b1;
        end
      end
      S_GAP: begin
        if (I2C_EN) begin
          if (gap_q > GAP_W'(1)) begin
            gap_n = gap_q - GAP_W'(1);
          end else
`ifdef I2C_CFG_READBACK_EN
          if (rd_q) begin
            state_n = S_RD_ISSUE;
          end else
`endif
          if (adv_q) begin
            if (idx_q == LAST_IDX) begin
              state_n = S_DONE;
              done_n  = 1'b1;
              busy_n  = 1'b0;
            end else begin
              idx_n   = idx_q + IDX_W'(1);
              retry_n = '0;
              state_n = S_LOAD;
            end
          end else begin
            state_n = S_LOAD;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign LUT_INDEX = idx_q;
  assign I2C_WDATA = wdata_q;
  assign GO        = go_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERROR     = err_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Self-checking bench for i2c_config_sequencer: a transaction-level model of the
// table walk plus a byte-controller responder and a per-cycle output checker.
module tb_i2c_config_sequencer;

  localparam int         CLK_DIV   = 4;
  localparam int         LUT_SIZE  = 3;
  localparam int         MAX_RETRY = 3;
  localparam int         GAP_TICKS = 4;
  localparam logic [7:0] DEV_ADDR  = 8'h42;

  logic        iCLK   = 1'b0;
  logic        iRST_N = 1'b0;
  logic        START  = 1'b0;
  logic        ACK    = 1'b1;
  logic        END    = 1'b0;
  logic [7:0]  LUT_INDEX;
  logic [15:0] LUT_DATA;
  logic        I2C_CLK, I2C_EN, WR, GO, BUSY, DONE, ERROR;
  logic [23:0] I2C_WDATA;
`ifdef I2C_CFG_READBACK_EN
  logic [7:0]  I2C_RDATA = 8'h00;
`endif

  logic [15:0] rom [0:3] = '{16'h0A11, 16'h1B5B, 16'h2C77, 16'h0000};
  assign LUT_DATA = rom[LUT_INDEX[1:0]];

  i2c_config_sequencer #(
    .CLK_DIV(CLK_DIV), .LUT_SIZE(LUT_SIZE), .DEV_ADDR(DEV_ADDR),
    .MAX_RETRY(MAX_RETRY), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .START(START), .LUT_INDEX(LUT_INDEX),
    .LUT_DATA(LUT_DATA), .I2C_CLK(I2C_CLK), .I2C_EN(I2C_EN),
    .I2C_WDATA(I2C_WDATA), .WR(WR), .GO(GO), .ACK(ACK), .END(END),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
`ifdef I2C_CFG_READBACK_EN
    , .I2C_RDATA(I2C_RDATA)
`endif
  );

  always #5 iCLK = ~iCLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Transaction-level model: expected GO bursts in order, plus the final outcome.
  typedef struct {
    bit          wr;
    logic [7:0]  idx;
    logic [23:0] wdata;
  } xfer_t;

  xfer_t expq[$];
  bit    model_fail;
  int    model_idx;
  int    nack_w   [4] = '{0, 0, 0, 0};
  int    nack_left[4] = '{0, 0, 0, 0};
  int    wr_cnt = 0;
`ifdef I2C_CFG_READBACK_EN
  int    bad_rd   [4] = '{0, 0, 0, 0};
  int    bad_left [4] = '{0, 0, 0, 0};
`endif

  task automatic build_model();
    xfer_t t;
    expq.delete();
    model_fail = 1'b0;
    model_idx  = LUT_SIZE - 1;
    for (int i = 0; i < LUT_SIZE; i++) begin
      int nw = nack_w[i];
`ifdef I2C_CFG_READBACK_EN
      int nb = bad_rd[i];
`endif
      int tries = 0;
      bit ok;
      while (1) begin
        t.wr = 1'b1; t.idx = 8'(i); t.wdata = {DEV_ADDR, rom[i]};
        expq.push_back(t);
        ok = 1'b1;
        if (nw > 0) begin
          nw--; ok = 1'b0;
        end
`ifdef I2C_CFG_READBACK_EN
        else begin
          t.wr = 1'b0;
          expq.push_back(t);
          if (nb > 0) begin nb--; ok = 1'b0; end
        end
`endif
        if (ok) break;
        if (tries == MAX_RETRY) begin
          model_fail = 1'b1; model_idx = i;
          break;
        end
        tries++;
      end
      if (model_fail) break;
    end
  endtask

  // Byte-controller responder: END three SCL ticks after GO, cleared on the tick after GO drops.
  initial begin : ctl
    int         phase = 0;
    int         tcnt = 0;
    int         gap_ticks = GAP_TICKS;
    bit         cur_wr = 1'b1;
    logic [7:0] cur_idx = 8'h00;
    xfer_t      e;
    forever begin
      @(negedge iCLK);
      if (!iRST_N) begin
        phase = 0; END = 1'b0; ACK = 1'b1; gap_ticks = GAP_TICKS;
        continue;
      end
      if (!GO && I2C_EN) gap_ticks++;
      case (phase)
        0: if (GO) begin
          cur_wr = WR; cur_idx = LUT_INDEX;
          if (cur_wr) wr_cnt++;
          checks++;
          if (gap_ticks < GAP_TICKS) begin
            failures++;
            $display("FAIL go_gap_ticks actual=%0d required>=%0d", gap_ticks, GAP_TICKS);
          end
          gap_ticks = 0;
          if (expq.size() == 0) begin
            check("unexpected_go_idx", LUT_INDEX, 32'hFFFF_FFFF);
          end else begin
            e = expq.pop_front();
            check("go_wr", WR, e.wr);
            check("go_index", LUT_INDEX, e.idx);
            check("go_wdata", I2C_WDATA, e.wdata);
          end
          tcnt = 0; phase = 1;
        end
        1: if (I2C_EN) begin
          tcnt++;
          if (tcnt == 3) begin
            END = 1'b1;
            if (cur_wr) begin
              if (nack_left[cur_idx[1:0]] > 0) begin
                ACK = 1'b1; nack_left[cur_idx[1:0]]--;
              end else ACK = 1'b0;
            end
`ifdef I2C_CFG_READBACK_EN
            else begin
              ACK = 1'b0;
              I2C_RDATA = rom[cur_idx[1:0]][7:0];
              if (bad_left[cur_idx[1:0]] > 0) begin
                I2C_RDATA = I2C_RDATA ^ 8'h01; bad_left[cur_idx[1:0]]--;
              end
            end
`endif
            phase = 2;
          end
        end
        2: if (!GO) phase = 3;
        default: if (I2C_EN) begin
          END = 1'b0; ACK = 1'b1; phase = 0;
        end
      endcase
    end
  end

  // Per-cycle checks; k counts clock edges since reset was released.
  initial begin : cmp
    int   k = 0;
    bit   first = 1'b1;
    logic prev_rst = 1'b0;
    logic prev_eg = 1'b0;
    forever begin
      @(negedge iCLK); #2;
      if (prev_rst) k++; else k = 0;
      if (!first) begin
        check("scl_level", I2C_CLK, ((k / CLK_DIV) % 2) == 0);
        check("en_tick", I2C_EN, (k % (2 * CLK_DIV)) == CLK_DIV);
        check("done_error_excl", DONE & ERROR, 0);
`ifndef I2C_CFG_READBACK_EN
        check("wr_const", WR, 1);
`endif
        if (GO) check("go_wdata_rom", I2C_WDATA, {DEV_ADDR, rom[LUT_INDEX[1:0]]});
        if (prev_eg) check("go_low_after_end", GO, 0);
      end
      first    = 1'b0;
      prev_rst = iRST_N;
      prev_eg  = GO & END & iRST_N;
    end
  end

  task automatic kick_start(input string nm);
    @(negedge iCLK); START = 1'b1;
    @(negedge iCLK); START = 1'b0; #1;
    check({nm, "_busy_set"}, BUSY, 1);
    check({nm, "_done_clr"}, DONE, 0);
    check({nm, "_error_clr"}, ERROR, 0);
    check({nm, "_go_lat1"}, GO, 0);
    @(negedge iCLK); #1;
    check({nm, "_go_lat2"}, GO, 0);
    @(negedge iCLK); #1;
    check({nm, "_go_lat3"}, GO, 1);
    check({nm, "_first_wdata"}, I2C_WDATA, 24'h420A11);
  endtask

  task automatic run_table(input string nm, input int nw0, input int nw1, input int nw2,
                           input int exp_writes, input bit poke);
    int n = 0;
    nack_w = '{nw0, nw1, nw2, 0};
    nack_left = nack_w;
`ifdef I2C_CFG_READBACK_EN
    bad_left = bad_rd;
`endif
    build_model();
    wr_cnt = 0;
    kick_start(nm);
    if (poke) begin
      repeat (20) @(negedge iCLK);
      START = 1'b1;
      @(negedge iCLK); START = 1'b0;
    end
    while (!(DONE || ERROR) && n < 4000) begin
      @(negedge iCLK); n++;
    end
    check({nm, "_finished_in_budget"}, n < 4000, 1);
    repeat (100) @(negedge iCLK);
    #1;
    check({nm, "_done"}, DONE, !model_fail);
    check({nm, "_error"}, ERROR, model_fail);
    check({nm, "_busy_clr"}, BUSY, 0);
    check({nm, "_index"}, LUT_INDEX, model_idx);
    check({nm, "_writes"}, wr_cnt, exp_writes);
    check({nm, "_bursts_left"}, expq.size(), 0);
    check({nm, "_go_idle"}, GO, 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c;
    iRST_N = 1'b0;
    repeat (2) @(negedge iCLK);
    #1;
    check("rst_index", LUT_INDEX, 0);
    check("rst_go", GO, 0);
    check("rst_wr", WR, 1);
    check("rst_wdata", I2C_WDATA, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_error", ERROR, 0);
    check("rst_scl", I2C_CLK, 1);
    check("rst_en", I2C_EN, 0);
    @(negedge iCLK); iRST_N = 1'b1;

    run_table("clean", 0, 0, 0, 3, 1'b1);
    run_table("retry_e1", 0, 2, 0, 5, 1'b0);
    run_table("fail_e2", 0, 0, 9, 6, 1'b0);

    // Reset while a transaction is waiting for END.
    nack_w = '{0, 0, 0, 0};
    nack_left = nack_w;
    build_model();
    kick_start("rst_mid");
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b0;
    @(negedge iCLK); #1;
    check("rst_mid_go", GO, 0);
    check("rst_mid_busy", BUSY, 0);
    check("rst_mid_index", LUT_INDEX, 0);
    check("rst_mid_scl", I2C_CLK, 1);
    expq.delete();
    @(negedge iCLK); iRST_N = 1'b1;
    c = 0;
    do begin @(negedge iCLK); #1; c++; end while (!I2C_EN && c < 50);
    check("first_tick_after_reset", c, CLK_DIV);
    c = 0;
    do begin @(negedge iCLK); #1; c++; end while (!I2C_EN && c < 50);
    check("tick_period", c, 2 * CLK_DIV);
    run_table("after_reset", 0, 0, 0, 3, 1'b0);

`ifdef I2C_CFG_READBACK_EN
    bad_rd = '{0, 1, 0, 0};
    run_table("readback_retry", 0, 0, 0, 4, 1'b0);
    bad_rd = '{0, 0, 0, 0};
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
